// File: rtl/mult_seq_32bit_pkg.sv
// Shared constants and types for the sequential arithmetic units.
// The product type is 64 bits wide so a future divider can use the same type.
package mult_seq_32bit_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [2*WIDTH-1:0] prod_t;

endpackage

// File: rtl/mult_seq_32bit_negate.sv
// Combinational two's-complement negation (~x + 1).
// Used both to take operand magnitudes and to restore the sign of the product.
module negate_64bit #(
  parameter int W = 64
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = ~value + W'(1);

endmodule

// File: rtl/mult_seq_32bit.sv
// Iterative shift-add multiplier: one partial product per cycle, 32 cycles per operation.
// Signed operands are multiplied as magnitudes, and the sign is applied to the 64-bit result.
module mult_seq_32bit #(
  parameter int WIDTH = mult_seq_32bit_pkg::WIDTH,
  parameter int CNT_W = mult_seq_32bit_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mult_seq_32bit_pkg::*;

  localparam int PW = 2 * WIDTH;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]   acc_hi_reg, acc_hi_next;
  logic [WIDTH-1:0]   acc_lo_reg, acc_lo_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               neg_reg, neg_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;

  logic [WIDTH-1:0]   a_neg, b_neg, a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [PW-1:0]      prod_raw, prod_neg, prod_fixed;

  negate_64bit #(.W(WIDTH)) u_neg_a (.value(a),        .result(a_neg));
  negate_64bit #(.W(WIDTH)) u_neg_b (.value(b),        .result(b_neg));
  negate_64bit #(.W(PW))    u_neg_p (.value(prod_raw), .result(prod_neg));

  // -2^31 negates to itself, which read as unsigned is exactly its magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? a_neg : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? b_neg : b;

  // acc_lo starts out holding the multiplier. Multiplier bits leave from the
  // bottom while product bits enter at the top, so acc_lo[0] is the current multiplier bit.
  assign sum        = acc_lo_reg[0] ? ({1'b0, acc_hi_reg} + {1'b0, mcand_reg})
                                    : {1'b0, acc_hi_reg};
  assign prod_raw   = {sum, acc_lo_reg[WIDTH-1:1]};
  assign prod_fixed = neg_reg ? prod_neg : prod_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    acc_hi_next = acc_hi_reg;
    acc_lo_next = acc_lo_reg;
    count_next  = count_reg;
    neg_next    = neg_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          mcand_next  = a_mag;
          acc_lo_next = b_mag;
          acc_hi_next = '0;
          neg_next    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          count_next  = '0;
          busy_next   = 1'b1;
        end
      end
      RUN: begin
        acc_hi_next = sum[WIDTH:1];
        acc_lo_next = {sum[0], acc_lo_reg[WIDTH-1:1]};
        count_next  = count_reg + CNT_W'(1);
        if (count_reg == CNT_W'(WIDTH - 1)) begin
          {hi_next, lo_next} = prod_fixed;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      count_reg  <= '0;
      neg_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      mcand_reg  <= mcand_next;
      acc_hi_reg <= acc_hi_next;
      acc_lo_reg <= acc_lo_next;
      count_reg  <= count_next;
      neg_reg    <= neg_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_seq_32bit.sv
// Directed testbench for mult_seq_32bit. The expected products are computed by hand.
// Outputs are sampled on the falling clock edge.
module tb_mult_seq_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors     = 0;
  int miscompares = 0;
  int cyc, busy_cyc, cnt;

  mult_seq_32bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge after the edge that samples start.
  task automatic launch(input logic s, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    is_signed = s; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int c, output int bc);
    c = 0; bc = 0;
    while (!done && c < 40) begin
      if (busy) bc++;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    int c, bc;
    launch(s, av, bv);
    wait_done(c, bc);
    chk({tag, " latency"}, 64'(c), 64'd32);
    chk({tag, " busy cycles"}, 64'(bc), 64'd32);
    chk({tag, " busy at done"}, 64'(busy), 64'd0);
    chk({tag, " product"}, {hi, lo}, {eh, el});
    $display("op %s: signed=%0d a=%h b=%h -> hi=%h lo=%h after %0d cycles", tag, s, av, bv, hi, lo, c);
    @(negedge clk);
    chk({tag, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {28'd0, busy, done, 34'd0} | {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", {busy, done, hi, lo}, 66'd0);

    run_op("unsigned max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("signed -3*7", 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("unsigned fffffffd*7", 1'b0, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
    run_op("signed min*min", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("signed min*1", 1'b1, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000);

    // start held high; operand changes during RUN must be ignored
    @(negedge clk);
    is_signed = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    a = 32'd100; b = 32'd200;
    wait_done(cyc, busy_cyc);
    chk("held start latency", 64'(cyc), 64'd32);
    chk("held start product", {hi, lo}, 64'd30);
    $display("op held start: a=5 b=6 -> hi=%h lo=%h after %0d cycles", hi, lo, cyc);
    a = 32'd7; b = 32'd9;
    @(negedge clk);
    chk("b2b done width", 64'(done), 64'd0);
    chk("b2b restarted busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(cyc, busy_cyc);
    chk("b2b latency", 64'(cyc), 64'd32);
    chk("b2b product", {hi, lo}, 64'd63);
    $display("op back-to-back: a=7 b=9 -> hi=%h lo=%h after %0d cycles", hi, lo, cyc);
    @(negedge clk);
    chk("b2b done drop", 64'(done), 64'd0);

    // asynchronous abort in the middle of an operation
    launch(1'b0, 32'd10, 32'd10);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort outputs", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("no activity after abort", 64'(cnt), 64'd0);
    $display("op abort: a=10 b=10 reset mid-run, hi=%h lo=%h", hi, lo);
    run_op("after abort 2*3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

    run_op("zero operand", 1'b0, 32'd0, 32'h12345678, 32'd0, 32'd0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0 || busy !== 1'b0) cnt++;
    end
    chk("hold stable 100 cycles", 64'(cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
